// File: rtl/prog_mem_loader_if.sv
// Stream and memory-write bus between the program loader and its surroundings.
// The master side is the loader: it accepts stream bytes and drives the memory
// write port. The slave side is the byte source plus the memory being filled.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Byte-stream program loader: takes a 16-bit big-endian length header followed
// by that many payload bytes, writes them to consecutive byte addresses, and
// keeps the PPU in reset until the whole image has landed in memory.
module prog_mem_loader #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int MAX_BYTES = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    prog_mem_loader_if.master   bus,
    output logic                cpu_reset_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [ADDR_W:0]     byte_count_o,
    output logic [7:0]          checksum_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_HI = 3'd1;
    localparam logic [2:0] HDR_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] FLUSH  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MAX_LEN = 17'(MAX_BYTES);

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   byte_count_q, byte_count_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              inReady;
    logic              transfer;
    logic [15:0]       fullLen;
    logic [ADDR_W:0]   countNext;

    // Handshake readiness and busy flag depend on the current state alone.
    always_comb begin
        inReady = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
        busy_o  = inReady || (state_q == FLUSH);
    end

    assign transfer  = bus.in_valid && inReady;
    assign fullLen   = {len_hi_q, bus.in_data};
    assign countNext = byte_count_q + 1'b1;

    // Next-state logic: header capture, payload writes and the status flags,
    // which are registered from the state being entered.
    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d      = HDR_HI;
                    byte_count_d = '0;
                    checksum_d   = '0;
                end
            end
            HDR_HI: begin
                if (transfer) begin
                    len_hi_d = bus.in_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (transfer) begin
                    len_d = fullLen;
                    if (fullLen == 16'd0)
                        state_d = DONE;
                    else if ({1'b0, fullLen} > MAX_LEN)
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (transfer) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = BASE + byte_count_q[ADDR_W-1:0];
                    mem_wdata_d  = bus.in_data;
                    byte_count_d = countNext;
                    checksum_d   = checksum_q + bus.in_data;
                    if (16'(countNext) == len_q)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_reset_d = (state_d != DONE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    // State and output registers; reset abandons any image in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_hi_q     <= '0;
            len_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_reset_o   = cpu_reset_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign byte_count_o  = byte_count_q;
    assign checksum_o    = checksum_q;
endmodule
